// File: rtl/ss_mult_sequencer.sv
// Windowed stochastic-symbol multiply controller: latches an operand pair, drives
// two LFSR random streams for 2^LOG_LEN cycles and returns the accumulated product.
module ss_mult_sequencer #(
    parameter int unsigned LOG_LEN = 8,
    parameter logic [7:0]  X_SEED  = 8'hA5,
    parameter logic [7:0]  Y_SEED  = 8'h3C
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [11:0]           x_input,
    input  logic [11:0]           y_input,
    input  logic                  abort,
    output logic [11:0]           x_op,
    output logic [11:0]           y_op,
    output logic [7:0]            x_randnum,
    output logic [7:0]            y_randnum,
    input  logic [9:0]            z_ss,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10+LOG_LEN-1:0] z_output
);

    localparam int unsigned AW = 10 + LOG_LEN;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LOG_LEN-1:0] count;
    logic [AW-1:0]      acc;
    logic [AW-1:0]      acc_sum;
    logic               last;
    logic               accept;
    logic               step;
    logic               finish;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr_next(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    endfunction

    assign acc_sum = acc + AW'(z_ss);
    assign last    = (count == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort takes priority over the final accumulate of the window.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_op      <= '0;
            y_op      <= '0;
            x_randnum <= X_SEED;
            y_randnum <= Y_SEED;
            acc       <= '0;
            count     <= '0;
            z_output  <= '0;
        end else if (accept) begin
            x_op      <= x_input;
            y_op      <= y_input;
            x_randnum <= X_SEED;
            y_randnum <= Y_SEED;
            acc       <= '0;
            count     <= '0;
        end else if (step) begin
            acc       <= acc_sum;
            x_randnum <= lfsr_next(x_randnum);
            y_randnum <= lfsr_next(y_randnum);
            count     <= count + LOG_LEN'(1);
            if (finish) begin
                z_output <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_ss_mult_sequencer.sv
// Bench for ss_mult_sequencer: a LOG_LEN=4 instance driven from a vector table and a
// LOG_LEN=8 instance for long-window, abort, datapath-model and async-reset sequences.
module tb_ss_mult_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // instance A: LOG_LEN = 4
    logic        a_in_valid = 1'b0, a_in_ready, a_abort = 1'b0, a_busy, a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [11:0] a_x_input = '0, a_y_input = '0, a_x_op, a_y_op;
    logic [7:0]  a_xr, a_yr;
    logic [9:0]  a_z_ss = '0;
    logic [13:0] a_z_output;

    // instance B: LOG_LEN = 8
    logic        b_in_valid = 1'b0, b_in_ready, b_abort = 1'b0, b_busy, b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [11:0] b_x_input = '0, b_y_input = '0, b_x_op, b_y_op;
    logic [7:0]  b_xr, b_yr;
    logic [9:0]  b_z_ss, b_z_const = '0;
    logic        use_model = 1'b0;
    logic [17:0] b_z_output;

    ss_mult_sequencer #(.LOG_LEN(4), .X_SEED(8'hA5), .Y_SEED(8'h3C)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x_input(a_x_input), .y_input(a_y_input), .abort(a_abort),
        .x_op(a_x_op), .y_op(a_y_op), .x_randnum(a_xr), .y_randnum(a_yr),
        .z_ss(a_z_ss), .busy(a_busy), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .z_output(a_z_output)
    );

    ss_mult_sequencer #(.LOG_LEN(8), .X_SEED(8'hA5), .Y_SEED(8'h3C)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x_input(b_x_input), .y_input(b_y_input), .abort(b_abort),
        .x_op(b_x_op), .y_op(b_y_op), .x_randnum(b_xr), .y_randnum(b_yr),
        .z_ss(b_z_ss), .busy(b_busy), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .z_output(b_z_output)
    );

    // reference LFSR, generator and multiplier
    function automatic logic [7:0] m_lfsr(input logic [7:0] r);
        logic fb;
        fb = r[7] ^ r[5] ^ r[4] ^ r[3];
        return {r[6:0], fb};
    endfunction

    function automatic logic [4:0] m_gen(input logic [11:0] op, input logic [7:0] r);
        if (r < op[11:4]) return 5'd31 - {2'b00, r[2:0]};
        return r[4:0] ^ op[4:0];
    endfunction

    function automatic logic [9:0] m_z(input logic [11:0] ox, input logic [7:0] rx,
                                       input logic [11:0] oy, input logic [7:0] ry);
        return 10'(m_gen(ox, rx)) * 10'(m_gen(oy, ry));
    endfunction

    always_comb b_z_ss = use_model ? m_z(b_x_op, b_xr, b_y_op, b_yr) : b_z_const;

    int unsigned qa[$];
    int unsigned qb[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboards: compare on the cycle a handshake is about to complete
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_unexpected_result: got %0d expected none", a_z_output);
            end else begin
                check("a_z_output", longint'(a_z_output), longint'(qa.pop_front()));
            end
        end
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_unexpected_result: got %0d expected none", b_z_output);
            end else begin
                check("b_z_output", longint'(b_z_output), longint'(qb.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int unsigned z;
        int unsigned exp;
    } vec_t;

    initial begin
        vec_t        tbl[5];
        int          edges;
        int          busy_n;
        bit          seen;
        logic [7:0]  rx, ry;
        int unsigned sum;

        tbl[0] = '{z: 0,   exp: 0};
        tbl[1] = '{z: 3,   exp: 48};
        tbl[2] = '{z: 961, exp: 15376};
        tbl[3] = '{z: 100, exp: 1600};
        tbl[4] = '{z: 31,  exp: 496};

        // reset values
        tick(); tick();
        check("rst_in_ready", b_in_ready, 1);
        check("rst_busy", b_busy, 0);
        check("rst_out_valid", b_out_valid, 0);
        check("rst_z_output", b_z_output, 0);
        check("rst_x_op", b_x_op, 0);
        check("rst_xr", b_xr, 8'hA5);
        check("rst_yr", b_yr, 8'h3C);
        rst = 1'b0;
        tick();

        // lone window on B: LFSR sequence from seed
        b_z_const = 10'd0; b_x_input = 12'h0AB; b_y_input = 12'h0CD;
        b_in_valid = 1'b1; qb.push_back(0);
        tick(); b_in_valid = 1'b0;
        check("lfsr_x0", b_xr, 8'hA5);
        check("lfsr_y0", b_yr, 8'h3C);
        check("b_y_op", b_y_op, 12'h0CD);
        tick(); check("lfsr_x1", b_xr, 8'h4A);
        tick(); check("lfsr_x2", b_xr, 8'h95);
        edges = 2;
        while (!b_out_valid && edges < 300) begin tick(); edges++; end
        check("b_lone_latency", edges, 256);
        tick();

        // table-driven constant-product windows on A
        for (int i = 0; i < 5; i++) begin
            a_z_ss = 10'(tbl[i].z); a_x_input = 12'(i * 37); a_in_valid = 1'b1;
            qa.push_back(tbl[i].exp);
            tick(); a_in_valid = 1'b0;
            check("a_x_op", a_x_op, i * 37);
            edges = 0; busy_n = 0;
            while (!a_out_valid && edges < 40) begin
                if (a_busy) busy_n++;
                tick(); edges++;
            end
            check("a_valid_latency", edges, 16);
            check("a_busy_cycles", busy_n, 16);
            tick();
            check("a_idle_after", a_in_ready, 1);
        end

        // maximum sum on B with stalled consumer
        b_out_ready = 1'b0; b_z_const = 10'd961; b_in_valid = 1'b1;
        qb.push_back(246016);
        tick(); b_in_valid = 1'b0;
        edges = 0;
        while (!b_out_valid && edges < 300) begin tick(); edges++; end
        check("b_max_latency", edges, 256);
        for (int k = 0; k < 5; k++) begin
            check("hold_out_valid", b_out_valid, 1);
            check("hold_z_output", b_z_output, 246016);
            check("hold_in_ready", b_in_ready, 0);
            tick();
        end
        b_out_ready = 1'b1;
        tick();
        check("post_hs_out_valid", b_out_valid, 0);
        check("post_hs_in_ready", b_in_ready, 1);

        // abort on the 7th RUN cycle
        b_z_const = 10'd5; b_in_valid = 1'b1;
        tick(); b_in_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("pre_abort_busy", b_busy, 1);
        b_abort = 1'b1;
        tick(); b_abort = 1'b0;
        check("abort_busy", b_busy, 0);
        check("abort_in_ready", b_in_ready, 1);
        check("abort_z_output", b_z_output, 246016);
        seen = 1'b0;
        for (int k = 0; k < 270; k++) begin
            seen |= b_out_valid;
            tick();
        end
        check("abort_no_valid", seen, 0);

        // abort coincident with the final accumulate
        b_in_valid = 1'b1;
        tick(); b_in_valid = 1'b0;
        for (int k = 0; k < 255; k++) tick();
        check("final_cycle_busy", b_busy, 1);
        b_abort = 1'b1;
        tick(); b_abort = 1'b0;
        check("final_abort_out_valid", b_out_valid, 0);
        check("final_abort_busy", b_busy, 0);
        check("final_abort_z_output", b_z_output, 246016);
        tick(); tick();
        check("final_abort_still_idle", b_out_valid, 0);

        // datapath model over the full LFSR window, with in_valid noise during RUN
        rx = 8'hA5; ry = 8'h3C; sum = 0;
        for (int k = 0; k < 256; k++) begin
            sum += int'(m_z(12'h800, rx, 12'h800, ry));
            rx = m_lfsr(rx);
            ry = m_lfsr(ry);
        end
        qb.push_back(sum);
        use_model = 1'b1; b_x_input = 12'h800; b_y_input = 12'h800; b_in_valid = 1'b1;
        tick(); b_in_valid = 1'b0;
        edges = 0;
        while (!b_out_valid && edges < 300) begin
            b_in_valid = (edges == 50 || edges == 51 || edges == 120);
            b_x_input  = b_in_valid ? 12'h123 : 12'h800;
            tick(); edges++;
        end
        b_in_valid = 1'b0; b_x_input = 12'h800;
        check("model_latency", edges, 256);
        check("model_x_op_held", b_x_op, 12'h800);
        tick();

        // asynchronous reset in RUN cycle 100
        b_in_valid = 1'b1;
        tick(); b_in_valid = 1'b0;
        for (int k = 0; k < 99; k++) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", b_busy, 0);
        check("arst_in_ready", b_in_ready, 1);
        check("arst_out_valid", b_out_valid, 0);
        check("arst_z_output", b_z_output, 0);
        check("arst_x_op", b_x_op, 0);
        check("arst_xr", b_xr, 8'hA5);
        check("arst_yr", b_yr, 8'h3C);
        rst = 1'b0;
        b_x_input = 12'h456; b_in_valid = 1'b1;
        tick(); b_in_valid = 1'b0;
        check("post_rst_accept_busy", b_busy, 1);
        check("post_rst_accept_x_op", b_x_op, 12'h456);
        b_abort = 1'b1;
        tick(); b_abort = 1'b0;
        tick(); tick();

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
